// File: rtl/demux_chan_counter.sv
// demux_chan_counter
// Per-channel rising-edge counter for the four outputs of a 1-to-4 demux.
// Each channel has a saturating counter. A one-cycle-latency read port returns
// a counter value and can optionally clear that counter. A sticky flag reports
// any sample in which more than one demux output was high.

module demux_chan_counter #(
    parameter int CNT_W     = 8,
    parameter bit CLR_ON_RD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    input  logic             err_clr,
    output logic             onehot_err
);

    localparam int NUM_CH = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Channel i corresponds to bit i: a=0, b=1, c=2, d=3.
    logic [NUM_CH-1:0] in_vec;
    logic [NUM_CH-1:0] prev_reg;
    logic [NUM_CH-1:0] edge_vec;

    // Every counter packed side by side, channel 0 in the low slice.
    logic [NUM_CH*CNT_W-1:0] cnt_flat;

    logic [CNT_W-1:0] rd_data_reg;
    logic [CNT_W-1:0] rd_data_next;
    logic             rd_valid_reg;
    logic             onehot_err_reg;
    logic             onehot_err_next;
    logic             multi_hot;

    assign in_vec   = {d, c, b, a};
    assign edge_vec = in_vec & ~prev_reg;

    // Hold the previous sample of each input. It resets to 0, so an input
    // that is already high on the first clock after reset counts as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= in_vec;
        end
    end

    // One saturating counter per channel. A clear-on-read of a channel takes
    // priority over its increment, but an edge on the same clock is kept by
    // restarting the counter at 1 instead of 0.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             rd_hit;

            assign rd_hit = CLR_ON_RD && rd_req && (rd_sel == 2'(gi));

            // Next-count selection: clear on read, else increment unless saturated.
            always_comb begin
                cnt_next = cnt_reg;
                if (rd_hit) begin
                    cnt_next = edge_vec[gi] ? CNT_ONE : '0;
                end else if (edge_vec[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            // Counter register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    // Select the requested counter's current (pre-update) value; hold the
    // previous read data when no read is requested.
    always_comb begin
        rd_data_next = rd_data_reg;
        if (rd_req) begin
            case (rd_sel)
                2'd0:    rd_data_next = cnt_flat[0*CNT_W +: CNT_W];
                2'd1:    rd_data_next = cnt_flat[1*CNT_W +: CNT_W];
                2'd2:    rd_data_next = cnt_flat[2*CNT_W +: CNT_W];
                default: rd_data_next = cnt_flat[3*CNT_W +: CNT_W];
            endcase
        end
    end

    // Read pipeline register: data plus a one-cycle valid pulse per request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_req;
        end
    end

    // Two or more outputs high at once: any pair being high covers it.
    assign multi_hot = (a & b) | (a & c) | (a & d) | (b & c) | (b & d) | (c & d);

    // Sticky error: a new violation wins over a simultaneous clear.
    always_comb begin
        onehot_err_next = onehot_err_reg;
        if (err_clr) begin
            onehot_err_next = 1'b0;
        end
        if (multi_hot) begin
            onehot_err_next = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            onehot_err_reg <= 1'b0;
        end else begin
            onehot_err_reg <= onehot_err_next;
        end
    end

    assign rd_data    = rd_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign onehot_err = onehot_err_reg;

endmodule

// File: tb/tb_demux_chan_counter.sv
// Testbench for demux_chan_counter. Three instances share clock and reset:
//   u0: CNT_W=8, clear-on-read; u1: CNT_W=4, clear-on-read; u2: CNT_W=8, no clear.
// Each instance has its own stimulus so every scenario targets one instance.
// Expected read values are pushed to a queue when the read is issued and
// popped when rd_valid is observed.

module tb_demux_chan_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] a_v = '0;
    logic [2:0] b_v = '0;
    logic [2:0] c_v = '0;
    logic [2:0] d_v = '0;
    logic [2:0] rd_req_v = '0;
    logic [2:0] err_clr_v = '0;
    logic [1:0] rd_sel_v [3];
    logic [7:0] rd_data0;
    logic [3:0] rd_data1;
    logic [7:0] rd_data2;
    logic [2:0] rd_valid_v;
    logic [2:0] onehot_err_v;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q [$];
    int exp_v;

    always #5 clk = ~clk;

    demux_chan_counter #(.CNT_W(8), .CLR_ON_RD(1'b1)) u0 (
        .clk(clk), .rst(rst), .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .d(d_v[0]),
        .rd_req(rd_req_v[0]), .rd_sel(rd_sel_v[0]), .rd_data(rd_data0),
        .rd_valid(rd_valid_v[0]), .err_clr(err_clr_v[0]), .onehot_err(onehot_err_v[0])
    );

    demux_chan_counter #(.CNT_W(4), .CLR_ON_RD(1'b1)) u1 (
        .clk(clk), .rst(rst), .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .d(d_v[1]),
        .rd_req(rd_req_v[1]), .rd_sel(rd_sel_v[1]), .rd_data(rd_data1),
        .rd_valid(rd_valid_v[1]), .err_clr(err_clr_v[1]), .onehot_err(onehot_err_v[1])
    );

    demux_chan_counter #(.CNT_W(8), .CLR_ON_RD(1'b0)) u2 (
        .clk(clk), .rst(rst), .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .d(d_v[2]),
        .rd_req(rd_req_v[2]), .rd_sel(rd_sel_v[2]), .rd_data(rd_data2),
        .rd_valid(rd_valid_v[2]), .err_clr(err_clr_v[2]), .onehot_err(onehot_err_v[2])
    );

    function automatic int rdat(int inst);
        case (inst)
            0:       return int'(rd_data0);
            1:       return int'(rd_data1);
            default: return int'(rd_data2);
        endcase
    endfunction

    // Drive a one-cycle read request and queue its expected data. Returns at
    // the falling edge after the sampling clock, where the result is visible.
    task automatic issue_read(int inst, int sel, int exp);
        rd_req_v[inst] = 1'b1;
        rd_sel_v[inst] = 2'(sel);
        exp_q.push_back(exp);
        @(negedge clk);
        rd_req_v[inst] = 1'b0;
        $display("read inst=%0d sel=%0d expect=%0d", inst, sel, exp);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rd_valid_v[i] !== 1'b0 || rdat(i) !== 0 || onehot_err_v[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state inst=%0d: got valid=%b data=%0d err=%b, expected 0/0/0",
                         i, rd_valid_v[i], rdat(i), onehot_err_v[i]);
            end
        end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_edge();
        a_v[0] = 1'b1;
        repeat (5) @(negedge clk);
        a_v[0] = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            issue_read(0, 0, (r == 0) ? 1 : 0);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (rd_valid_v[0] !== 1'b1 || rdat(0) !== exp_v) begin
                n_err++;
                $display("FAIL single_edge_read%0d: got valid=%b data=%0d, expected valid=1 data=%0d",
                         r, rd_valid_v[0], rdat(0), exp_v);
            end
            @(negedge clk);
            n_cmp++;
            if (rd_valid_v[0] !== 1'b0) begin
                n_err++;
                $display("FAIL single_edge_pulse%0d: got valid=%b, expected 0", r, rd_valid_v[0]);
            end
        end
    endtask

    task automatic test_demux_step();
        for (int rep = 0; rep < 3; rep++) begin
            for (int s = 0; s < 4; s++) begin
                a_v[0] = (s == 0);
                b_v[0] = (s == 1);
                c_v[0] = (s == 2);
                d_v[0] = (s == 3);
                @(negedge clk);
            end
        end
        d_v[0] = 1'b0;
        @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            issue_read(0, ch, 3);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (rd_valid_v[0] !== 1'b1 || rdat(0) !== exp_v) begin
                n_err++;
                $display("FAIL demux_step_ch%0d: got valid=%b data=%0d, expected valid=1 data=%0d",
                         ch, rd_valid_v[0], rdat(0), exp_v);
            end
        end
        n_cmp++;
        if (onehot_err_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL demux_step_onehot: got %b, expected 0", onehot_err_v[0]);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            b_v[1] = 1'b1;
            @(negedge clk);
            b_v[1] = 1'b0;
            @(negedge clk);
        end
        for (int r = 0; r < 2; r++) begin
            issue_read(1, 1, (r == 0) ? 15 : 0);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (rd_valid_v[1] !== 1'b1 || rdat(1) !== exp_v) begin
                n_err++;
                $display("FAIL saturation_read%0d: got valid=%b data=%0d, expected valid=1 data=%0d",
                         r, rd_valid_v[1], rdat(1), exp_v);
            end
        end
    endtask

    task automatic test_coincident_edge();
        for (int i = 0; i < 6; i++) begin
            c_v[0] = 1'b1;
            @(negedge clk);
            c_v[0] = 1'b0;
            @(negedge clk);
        end
        c_v[0] = 1'b1;
        issue_read(0, 2, 6);
        c_v[0] = 1'b0;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_valid_v[0] !== 1'b1 || rdat(0) !== exp_v) begin
            n_err++;
            $display("FAIL coincident_read: got valid=%b data=%0d, expected valid=1 data=%0d",
                     rd_valid_v[0], rdat(0), exp_v);
        end
        issue_read(0, 2, 1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_valid_v[0] !== 1'b1 || rdat(0) !== exp_v) begin
            n_err++;
            $display("FAIL coincident_reread: got valid=%b data=%0d, expected valid=1 data=%0d",
                     rd_valid_v[0], rdat(0), exp_v);
        end
    endtask

    task automatic test_onehot_err();
        a_v[0] = 1'b1;
        b_v[0] = 1'b1;
        @(negedge clk);
        a_v[0] = 1'b0;
        b_v[0] = 1'b0;
        n_cmp++;
        if (onehot_err_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL onehot_set: got %b, expected 1", onehot_err_v[0]);
        end
        for (int ch = 0; ch < 2; ch++) begin
            issue_read(0, ch, 1);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (rd_valid_v[0] !== 1'b1 || rdat(0) !== exp_v) begin
                n_err++;
                $display("FAIL onehot_count_ch%0d: got valid=%b data=%0d, expected valid=1 data=%0d",
                         ch, rd_valid_v[0], rdat(0), exp_v);
            end
        end
        n_cmp++;
        if (onehot_err_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL onehot_sticky: got %b, expected 1", onehot_err_v[0]);
        end
        a_v[0] = 1'b1;
        b_v[0] = 1'b1;
        err_clr_v[0] = 1'b1;
        @(negedge clk);
        a_v[0] = 1'b0;
        b_v[0] = 1'b0;
        err_clr_v[0] = 1'b0;
        n_cmp++;
        if (onehot_err_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL onehot_set_wins: got %b, expected 1", onehot_err_v[0]);
        end
        err_clr_v[0] = 1'b1;
        @(negedge clk);
        err_clr_v[0] = 1'b0;
        n_cmp++;
        if (onehot_err_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL onehot_clear: got %b, expected 0", onehot_err_v[0]);
        end
        $display("test_onehot_err done");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            d_v[2] = 1'b1;
            @(negedge clk);
            d_v[2] = 1'b0;
            @(negedge clk);
        end
        rd_req_v[2] = 1'b1;
        rd_sel_v[2] = 2'd3;
        exp_q.push_back(4);
        exp_q.push_back(4);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            if (r == 1) rd_req_v[2] = 1'b0;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (rd_valid_v[2] !== 1'b1 || rdat(2) !== exp_v) begin
                n_err++;
                $display("FAIL back_to_back_read%0d: got valid=%b data=%0d, expected valid=1 data=%0d",
                         r, rd_valid_v[2], rdat(2), exp_v);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (rd_valid_v[2] !== 1'b0 || rdat(2) !== 4) begin
            n_err++;
            $display("FAIL back_to_back_hold: got valid=%b data=%0d, expected valid=0 data=4",
                     rd_valid_v[2], rdat(2));
        end
    endtask

    task automatic test_reset_mid_read();
        a_v[0] = 1'b1;
        c_v[0] = 1'b1;
        rd_req_v[2] = 1'b1;
        rd_sel_v[2] = 2'd3;
        exp_q.push_back(4);
        @(negedge clk);
        a_v[0] = 1'b0;
        c_v[0] = 1'b0;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_valid_v[2] !== 1'b1 || rdat(2) !== exp_v || onehot_err_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_read: got valid=%b data=%0d err=%b, expected 1/%0d/1",
                     rd_valid_v[2], rdat(2), onehot_err_v[0], exp_v);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (rd_valid_v[2] !== 1'b0 || rdat(2) !== 0 || onehot_err_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got valid=%b data=%0d err=%b, expected 0/0/0",
                     rd_valid_v[2], rdat(2), onehot_err_v[0]);
        end
        @(negedge clk);
        rd_req_v[2] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        issue_read(2, 3, 0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_valid_v[2] !== 1'b1 || rdat(2) !== exp_v) begin
            n_err++;
            $display("FAIL post_reset_ch3: got valid=%b data=%0d, expected valid=1 data=%0d",
                     rd_valid_v[2], rdat(2), exp_v);
        end
        issue_read(0, 2, 0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_valid_v[0] !== 1'b1 || rdat(0) !== exp_v) begin
            n_err++;
            $display("FAIL post_reset_u0_ch2: got valid=%b data=%0d, expected valid=1 data=%0d",
                     rd_valid_v[0], rdat(0), exp_v);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) rd_sel_v[i] = 2'd0;
        test_reset();
        test_single_edge();
        test_demux_step();
        test_saturation();
        test_coincident_edge();
        test_onehot_err();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
